// File: rtl/lsu_ctrl.sv
// Load/store controller: IDLE -> ACCESS -> RESP handshake FSM. Sizes, aligns and extends memory accesses.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses with resp_err instead of ignoring low address bits.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [3:0]  mem_strobe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic        lat_err;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    logic        dec_illegal;
    logic        dec_misalign;
    logic        dec_err;
    logic [3:0]  dec_strobe;
    logic [31:0] dec_wdata;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    // Decode the incoming request so the memory drive can be registered on acceptance.
    always_comb begin
        dec_illegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: dec_illegal = 1'b0;
            3'b100, 3'b101:         dec_illegal = req_we;
            default:                dec_illegal = 1'b1;
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        dec_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        dec_misalign = 1'b0;
`endif

        dec_err = dec_illegal | dec_misalign;

        dec_strobe = 4'b1111;
        dec_wdata  = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                dec_strobe = 4'b0001 << req_addr[1:0];
                dec_wdata  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                dec_strobe = req_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata  = {2{req_wdata[15:0]}};
            end
            default: begin
                dec_strobe = 4'b1111;
                dec_wdata  = req_wdata;
            end
        endcase
    end

    // Lane selection uses the latched offset since mem_rdata follows the registered word address.
    always_comb begin
        sel_byte  = mem_rdata[{lat_off, 3'b000} +: 8];
        sel_half  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (lat_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'h000000, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'h0000, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_we     <= 1'b0;
            mem_strobe <= 4'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_err    <= dec_err;
                        lat_funct3 <= req_funct3;
                        lat_off    <= req_addr[1:0];
                        // Rejected requests leave the memory bus completely quiet.
                        mem_we     <= req_we & ~dec_err;
                        mem_strobe <= dec_err ? 4'h0 : (req_we ? dec_strobe : 4'b1111);
                        mem_addr   <= dec_err ? 32'h0 : {req_addr[31:2], 2'b00};
                        mem_wdata  <= (dec_err || !req_we) ? 32'h0 : dec_wdata;
                        req_ready  <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we     <= 1'b0;
                    mem_strobe <= 4'h0;
                    mem_addr   <= 32'h0;
                    mem_wdata  <= 32'h0;
                    resp_err   <= lat_err;
                    resp_rdata <= (lat_we || lat_err) ? 32'h0 : load_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
